// File: rtl/conv_encoder_puncturer_if.sv
// conv_encoder_puncturer_if: control, input-side and output-side handshakes
// of the punctured convolutional encoder.
interface conv_encoder_puncturer_if;
    logic       Start;
    logic [1:0] Rate;
    logic       Input;
    logic       In_Valid;
    logic       In_Ready;
    logic       Output;
    logic       Out_Valid;
    logic       Out_Ready;

    modport master (
        output Start, Rate, Input, In_Valid, Out_Ready,
        input  In_Ready, Output, Out_Valid
    );

    modport slave (
        input  Start, Rate, Input, In_Valid, Out_Ready,
        output In_Ready, Output, Out_Valid
    );
endinterface

// File: rtl/conv_encoder_puncturer.sv
// conv_encoder_puncturer: bit-serial 802.11a K=7 convolutional encoder with
// rate 1/2, 2/3 and 3/4 puncturing, one coded bit per clock at most.
module conv_encoder_puncturer #(
    parameter int             K  = 7,
    parameter logic [K-1:0]   G0 = 7'b1011011,
    parameter logic [K-1:0]   G1 = 7'b1111001
) (
    input logic Clock,
    input logic Reset,
    conv_encoder_puncturer_if.slave bus
);
    logic [1:K-1] sr;
    logic [1:0]   phase;
    logic [1:0]   rate_q;
    logic [1:0]   last_phase;
    logic         pending;
    logic         pending_bit;
    logic         accept;
    logic         xfer;
    logic         bit_a;
    logic         bit_b;
    logic         keep_a;
    logic         keep_b;

    assign bus.In_Ready = !bus.Start && !pending && (!bus.Out_Valid || bus.Out_Ready);
    assign accept       = bus.In_Valid && bus.In_Ready;
    assign xfer         = bus.Out_Valid && bus.Out_Ready;
    // {current, s[1..K-1]} lines up with the generator bit order (MSB = current)
    assign bit_a        = ^({bus.Input, sr} & G0);
    assign bit_b        = ^({bus.Input, sr} & G1);
    assign last_phase   = rate_q == 2'b01 ? 2'd1 : rate_q == 2'b10 ? 2'd2 : 2'd0;
    assign keep_a       = !(rate_q == 2'b10 && phase == 2'd2);
    assign keep_b       = phase != 2'd1;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sr            <= '0;
            phase         <= '0;
            rate_q        <= '0;
            pending       <= 1'b0;
            pending_bit   <= 1'b0;
            bus.Output    <= 1'b0;
            bus.Out_Valid <= 1'b0;
        end else if (bus.Start) begin
            sr            <= '0;
            phase         <= '0;
            rate_q        <= bus.Rate == 2'b11 ? 2'b00 : bus.Rate;
            pending       <= 1'b0;
            bus.Out_Valid <= 1'b0;
        end else if (accept) begin
            sr            <= {bus.Input, sr[1:K-2]};
            phase         <= phase == last_phase ? 2'd0 : phase + 2'd1;
            bus.Output    <= keep_a ? bit_a : bit_b;
            bus.Out_Valid <= 1'b1;
            pending       <= keep_a && keep_b;
            pending_bit   <= bit_b;
        end else if (xfer) begin
            if (pending) begin
                bus.Output <= pending_bit;
                pending    <= 1'b0;
            end else begin
                bus.Out_Valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_encoder_puncturer.sv
// tb_conv_encoder_puncturer: directed impulse, back-pressure, Start and
// async-reset scenarios with hand-computed coded streams.
module tb_conv_encoder_puncturer;
    logic Clock;
    logic Reset;
    int   vectors = 0;
    int   errors  = 0;
    logic [31:0] got_vec;
    int   got_n;

    conv_encoder_puncturer_if bus ();

    conv_encoder_puncturer dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // a bit transfers on the next rising edge when valid and ready are both high here
    always @(negedge Clock) begin
        if (Reset && !bus.Start && bus.Out_Valid && bus.Out_Ready) begin
            got_vec = {got_vec[30:0], bus.Output};
            got_n   = got_n + 1;
        end
    end

    task automatic clear_got();
        got_vec = '0;
        got_n   = 0;
    endtask

    task automatic idle(input int c);
        repeat (c) @(posedge Clock);
        #1;
    endtask

    task automatic do_start(input logic [1:0] r);
        bus.Start    = 1'b1;
        bus.Rate     = r;
        bus.In_Valid = 1'b0;
        @(posedge Clock) #1;
        bus.Start = 1'b0;
        clear_got();
    endtask

    // drives bits[n-1] first, logging In_Ready per cycle and Out_Valid gaps
    task automatic feed(input logic [15:0] bits, input int n,
                        output logic [15:0] rlog, output int rn, output int bub);
        int idx = 0;
        int cyc = 0;
        rlog = '0;
        rn   = 0;
        bub  = 0;
        bus.In_Valid = 1'b1;
        bus.Input    = bits[n-1];
        while (idx < n && cyc < 100) begin
            @(negedge Clock);
            rlog = {rlog[14:0], bus.In_Ready};
            rn++;
            if (idx > 0 && !bus.Out_Valid) bub++;
            if (bus.In_Ready) idx++;
            @(posedge Clock) #1;
            cyc++;
            if (idx < n) bus.Input = bits[n-1-idx];
        end
        bus.In_Valid = 1'b0;
        vectors++;
        if (cyc >= 100) begin
            errors++;
            $display("FAIL feed_timeout: accepted %0d of %0d inputs", idx, n);
        end
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (bus.Out_Valid !== 1'b0 || bus.Output !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: Out_Valid=%b Output=%b, want 0 0", bus.Out_Valid, bus.Output);
        end
        @(negedge Clock) Reset = 1'b1;
        #1;
        vectors++;
        if (bus.In_Ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", bus.In_Ready);
        end
        @(posedge Clock) #1;
    endtask

    task automatic test_rate12_impulse();
        logic [15:0] rlog;
        int rn, bub;
        do_start(2'b00);
        feed(16'b1000000, 7, rlog, rn, bub);
        idle(4);
        vectors++;
        if (got_n !== 14 || got_vec[13:0] !== 14'b11011111001011) begin
            errors++;
            $display("FAIL r12_stream: got %0d bits %b want 14 bits 11011111001011", got_n, got_vec[13:0]);
        end
        vectors++;
        if (rn !== 13 || rlog[12:0] !== 13'b1010101010101) begin
            errors++;
            $display("FAIL r12_in_ready: got %0d cycles %b want 13 cycles 1010101010101", rn, rlog[12:0]);
        end
    endtask

    task automatic test_rate34_impulse();
        logic [15:0] rlog;
        int rn, bub;
        do_start(2'b10);
        feed(16'b100000, 6, rlog, rn, bub);
        idle(4);
        vectors++;
        if (got_n !== 8 || got_vec[7:0] !== 8'b11011100) begin
            errors++;
            $display("FAIL r34_stream: got %0d bits %b want 8 bits 11011100", got_n, got_vec[7:0]);
        end
        vectors++;
        if (rn !== 8 || rlog[7:0] !== 8'b10111011) begin
            errors++;
            $display("FAIL r34_in_ready: got %0d cycles %b want 8 cycles 10111011", rn, rlog[7:0]);
        end
        vectors++;
        if (bub !== 0) begin
            errors++;
            $display("FAIL r34_bubbles: got %0d want 0", bub);
        end
    endtask

    task automatic test_rate23_impulse();
        logic [15:0] rlog;
        int rn, bub;
        do_start(2'b01);
        feed(16'b1000, 4, rlog, rn, bub);
        idle(4);
        vectors++;
        if (got_n !== 6 || got_vec[5:0] !== 6'b110111) begin
            errors++;
            $display("FAIL r23_stream: got %0d bits %b want 6 bits 110111", got_n, got_vec[5:0]);
        end
        vectors++;
        if (rn !== 6 || rlog[5:0] !== 6'b101101) begin
            errors++;
            $display("FAIL r23_in_ready: got %0d cycles %b want 6 cycles 101101", rn, rlog[5:0]);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] head;
        do_start(2'b00);
        bus.Out_Ready = 1'b1;
        bus.In_Valid  = 1'b1;
        bus.Input     = 1'b1;
        @(posedge Clock) #1;
        bus.Out_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            vectors++;
            if (bus.Output !== 1'b1 || bus.Out_Valid !== 1'b1 || bus.In_Ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: Output=%b Out_Valid=%b In_Ready=%b want 1 1 0",
                         i, bus.Output, bus.Out_Valid, bus.In_Ready);
            end
            @(posedge Clock) #1;
        end
        bus.Out_Ready = 1'b1;
        repeat (8) @(posedge Clock);
        #1;
        bus.In_Valid = 1'b0;
        idle(4);
        head = got_n >= 6 ? got_vec >> (got_n - 6) : '0;
        vectors++;
        if (got_n !== 10 || head[5:0] !== 6'b111001) begin
            errors++;
            $display("FAIL bp_stream: got %0d bits head %b want 10 bits head 111001", got_n, head[5:0]);
        end
    endtask

    task automatic test_start_mid_stream();
        logic [15:0] rlog;
        int rn, bub;
        do_start(2'b00);
        bus.In_Valid = 1'b1;
        bus.Input    = 1'b1;
        @(posedge Clock) #1;
        bus.Start = 1'b1;
        bus.Rate  = 2'b10;
        @(negedge Clock);
        vectors++;
        if (bus.In_Ready !== 1'b0) begin
            errors++;
            $display("FAIL start_in_ready: got %b want 0", bus.In_Ready);
        end
        @(posedge Clock) #1;
        bus.Start    = 1'b0;
        bus.In_Valid = 1'b0;
        clear_got();
        @(negedge Clock);
        vectors++;
        if (bus.Out_Valid !== 1'b0) begin
            errors++;
            $display("FAIL start_out_valid: got %b want 0", bus.Out_Valid);
        end
        @(posedge Clock) #1;
        feed(16'b100000, 6, rlog, rn, bub);
        idle(4);
        vectors++;
        if (got_n !== 8 || got_vec[7:0] !== 8'b11011100) begin
            errors++;
            $display("FAIL start_stream: got %0d bits %b want 8 bits 11011100", got_n, got_vec[7:0]);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] rlog;
        int rn, bub;
        do_start(2'b10);
        bus.In_Valid = 1'b1;
        bus.Input    = 1'b1;
        @(posedge Clock) #1;
        bus.In_Valid = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        vectors++;
        if (bus.Out_Valid !== 1'b0 || bus.Output !== 1'b0) begin
            errors++;
            $display("FAIL areset_out: Out_Valid=%b Output=%b want 0 0", bus.Out_Valid, bus.Output);
        end
        @(negedge Clock) Reset = 1'b1;
        #1;
        vectors++;
        if (bus.In_Ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_in_ready: got %b want 1", bus.In_Ready);
        end
        @(posedge Clock) #1;
        clear_got();
        feed(16'b1000000, 7, rlog, rn, bub);
        idle(4);
        vectors++;
        if (got_n !== 14 || got_vec[13:0] !== 14'b11011111001011) begin
            errors++;
            $display("FAIL areset_stream: got %0d bits %b want 14 bits 11011111001011", got_n, got_vec[13:0]);
        end
    endtask

    initial begin
        Reset         = 1'b0;
        bus.Start     = 1'b0;
        bus.Rate      = 2'b00;
        bus.Input     = 1'b0;
        bus.In_Valid  = 1'b0;
        bus.Out_Ready = 1'b1;
        clear_got();
        test_reset();
        test_rate12_impulse();
        test_rate34_impulse();
        test_rate23_impulse();
        test_back_pressure();
        test_start_mid_stream();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
